mux3_rr_arbiter: RTL
====================

// Module: mux3_rr_arbiter
// PURPOSE
//   Round-robin arbiter that shares the 3:1 data mux (inputs u, v, w; selects s0, s1; output m)
//   between three requesters. Drives s0/s1 so that m carries the granted requester's data.
//   Bounds each owner's tenure to HOLD_MAX cycles while another requester is waiting.
//   Sits between the requesting logic and the mux; the mux itself stays purely combinational.
// PARAMETERS
//   HOLD_MAX  4  max consecutive grant cycles for one owner while another request is pending (>=1)
//   CNT_W     3  tenure counter width; must satisfy 2**CNT_W > HOLD_MAX
// PORTS
//   clk    in   1  single system clock, rising edge
//   rst_n  in   1  reset, asynchronous, active-low
//   en     in   1  arbiter enable; low forces release and blocks new grants
//   req    in   3  requests: [0]=u, [1]=v, [2]=w; level-sensitive, held until served
//   gnt    out  3  one-hot grant, same bit order as req; 000 = no owner
//   s0     out  1  mux select 0 (registered)
//   s1     out  1  mux select 1 (registered)
//   busy   out  1  1 when gnt!=000; m is valid only while busy=1
// BEHAVIOUR
//   Mux mapping (m = s1 ? w : (s0 ? v : u)): owner u -> s1s0=00, v -> 01, w -> 10. 11 is never driven.
//   Reset (async, rst_n=0): state=IDLE, gnt=000, s0=0, s1=0, busy=0, cnt=0, last=2 (u has first priority).
//   All outputs are registered; they change only on clk rising edge or async reset.
//   States: IDLE, GRANT.
//   Pick rule: first index with req=1 searching cyclically from last+1 (e.g. last=0 -> order 1,2,0).
//   IDLE: if en=1 and req!=000 -> GRANT next edge: gnt=onehot(pick), s1s0 per mapping, busy=1,
//     cnt=1, last=pick. Latency: request sampled at edge N -> gnt/s0/s1 valid after edge N.
//     Otherwise remain IDLE; s0/s1 hold their previous values.
//   GRANT, owner k, evaluated each edge in priority order:
//     1. en=0 -> IDLE, gnt=000, busy=0, cnt=0.
//     2. req[k]=0 -> release; if any other req=1, grant pick immediately (no bubble, cnt=1),
//        else IDLE, gnt=000, busy=0.
//     3. cnt==HOLD_MAX and another req=1 -> rotate to pick (k excluded), cnt=1.
//     4. else keep k; cnt=cnt+1, saturating at HOLD_MAX (no wrap).
//   Owner alone with req[k]=1 keeps the grant indefinitely; cnt saturates at HOLD_MAX, so a new
//     requester arriving later takes over on the first edge it is seen.
//   gnt is always one-hot or zero; s1s0 always matches gnt while busy=1.
//   Simultaneous requests: resolved only by the pick rule; no fixed priority after reset.
//   Reset mid-grant: outputs return to reset values immediately, without waiting for a clock edge;
//     after rst_n rises, arbitration restarts with u first.
//   en deassert and reassert: last is preserved, so fairness continues across enable gaps.
// TESTING
//   1. Reset, req=001, en=1 -> next edge gnt=001, s1s0=00, busy=1; drop req -> next edge gnt=000, busy=0.
//   2. req=111 held, HOLD_MAX=4 -> u 4 cycles, v 4 cycles, w 4 cycles, u ...; s1s0 = 00,01,10 in turn.
//   3. req=010 only, held 10 cycles -> gnt=010 for all 10 cycles; raise req[2] -> w granted next edge.
//   4. Owner v drops req while req[0]=1 -> gnt switches 010->001 in one edge, with no 000 cycle.
//   5. en=0 mid-grant -> gnt=000 next edge; en=1 with req=111 and last=v -> w granted next.
//   6. rst_n low between edges during grant -> gnt=000, s0=s1=0 immediately; after release, req=110 -> v granted.
//   Every cycle: assert gnt is one-hot or zero, s1s0!=11, and busy == |gnt.

Source files
------------

// File: rtl/mux3_rr_arbiter.sv
// Round-robin owner arbitration for a shared 3:1 mux (u, v, w). The grant, the mux selects and busy
// are all registered. One owner may hold the mux for at most HOLD_MAX cycles while another requester is waiting.
module mux3_rr_arbiter #(
  parameter int HOLD_MAX = 4,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic       s0,
  output logic       s1,
  output logic       busy
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       last_r;

  logic [2:0] others_s;
  logic [1:0] pick_all_s;
  logic [1:0] pick_oth_s;
  logic       take_s;
  logic [1:0] take_idx_s;
  logic       drop_s;
  logic       inc_s;

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      2'd2:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] nxt_idx(input logic [1:0] idx);
    nxt_idx = (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Search from last+1 cyclically. If nothing is found, the search falls back to last.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] l);
    logic [1:0] a;
    logic [1:0] b;
    a = nxt_idx(l);
    b = nxt_idx(a);
    if (r[a]) begin
      rr_pick = a;
    end else if (r[b]) begin
      rr_pick = b;
    end else begin
      rr_pick = l;
    end
  endfunction

  // Next-action decode: take a new owner, drop to idle, or keep the current owner
  always_comb begin
    others_s   = req & ~onehot(last_r);
    pick_all_s = rr_pick(req, last_r);
    pick_oth_s = rr_pick(others_s, last_r);
    take_s     = 1'b0;
    take_idx_s = pick_all_s;
    drop_s     = 1'b0;
    inc_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (en && (req != 3'b000)) begin
          take_s = 1'b1;
        end else begin
          drop_s = 1'b1;
        end
      end
      GRANT: begin
        if (!en) begin
          drop_s = 1'b1;
        end else if ((req & onehot(last_r)) == 3'b000) begin
          // The owner released. Hand over to a waiting requester in the same edge (no idle bubble).
          if (others_s != 3'b000) begin
            take_s     = 1'b1;
            take_idx_s = pick_oth_s;
          end else begin
            drop_s = 1'b1;
          end
        end else if ((cnt_r == HOLD_C) && (others_s != 3'b000)) begin
          take_s     = 1'b1;
          take_idx_s = pick_oth_s;
        end else begin
          inc_s = 1'b1;
        end
      end
      default: begin
        drop_s = 1'b1;
      end
    endcase
  end

  // State, tenure counter and registered outputs. s0/s1 keep their value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      gnt     <= 3'b000;
      s0      <= 1'b0;
      s1      <= 1'b0;
      busy    <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      last_r  <= 2'd2;
    end else if (take_s) begin
      state_r <= GRANT;
      gnt     <= onehot(take_idx_s);
      s0      <= (take_idx_s == 2'd1);
      s1      <= (take_idx_s == 2'd2);
      busy    <= 1'b1;
      cnt_r   <= CNT_ONE;
      last_r  <= take_idx_s;
    end else if (drop_s) begin
      state_r <= IDLE;
      gnt     <= 3'b000;
      busy    <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else if (inc_s && (cnt_r != HOLD_C)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

endmodule
